// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with a start/busy/done handshake and a registered borrow flip-flop.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One full-subtractor step built from two half subtractors: returns {bo, d}.
   function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic bi);
      logic d;
      logic bo;
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
      return {bo, d};
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic             load_s;
   logic             last_s;
   logic [1:0]       bit_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] diff_r;
   logic [CW-1:0]    count_r;
   logic             bff_r;
   logic             borrow_r;
   logic             busy_r;
   logic             done_r;

   assign bit_s  = sub_bit(a_r[0], b_r[0], bff_r);
   assign last_s = (count_r == CNT_LAST);

   assign busy   = busy_r;
   assign done   = done_r;
   assign diff   = diff_r;
   assign borrow = borrow_r;

   // Next-state decode; a start is only honoured from IDLE or DONE.
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = SHIFT;
               load_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SHIFT;
            end
         end
         DONE: begin
            if (start) begin
               next_state_s = SHIFT;
               load_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
            load_s       = 1'b0;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         res_r    <= {WIDTH{1'b0}};
         diff_r   <= {WIDTH{1'b0}};
         count_r  <= {CW{1'b0}};
         bff_r    <= 1'b0;
         borrow_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == SHIFT);
         done_r  <= (next_state_s == DONE);
         if (load_s) begin
            a_r     <= a;
            b_r     <= b;
            bff_r   <= 1'b0;
            count_r <= {CW{1'b0}};
         end else if (state_r == SHIFT) begin
            a_r     <= {1'b0, a_r[WIDTH-1:1]};
            b_r     <= {1'b0, b_r[WIDTH-1:1]};
            res_r   <= {bit_s[0], res_r[WIDTH-1:1]};
            bff_r   <= bit_s[1];
            count_r <= count_r + CNT_ONE;
            // The final bit goes straight to the visible result alongside the shift.
            if (last_s) begin
               diff_r   <= {bit_s[0], res_r[WIDTH-1:1]};
               borrow_r <= bit_s[1];
            end
         end
      end
   end

endmodule
